i2c_slave_ctrl: RTL and testbench

- Byte-oriented I2C target (slave) controller with a fixed 7-bit address.
- Oversamples SCL/SDA on a fast system clock, which must run at least 20x the SCL frequency (e.g. 100 MHz clk for a 5 MHz SCL).
- Supports single-byte write (master to slave) and multi-byte read (slave to master).
- Sits between the open-drain I2C pins and a simple parallel byte interface.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_slave_ctrl_if.sv | 26 ++
 rtl/i2c_line_sync.sv | 48 ++++
 rtl/i2c_slave_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encodings and constants for the I2C target controller
package i2c_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_READ      = 3'd4,
        ST_READ_ACK  = 3'd5,
        ST_WRITE_ACK = 3'd6
    } state_t;

    localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// rtl/i2c_slave_ctrl_if.sv - parallel byte-side interface of the I2C target controller
interface i2c_slave_ctrl_if;

    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_ready;
    logic       ack_error;
    logic       start;

    modport slave (
        input  data_in,
        output data_out,
        output data_ready,
        output ack_error,
        output start
    );

    modport master (
        output data_in,
        input  data_out,
        input  data_ready,
        input  ack_error,
        input  start
    );

endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - scl/sda synchronizers with edge, START and STOP detection
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [0],[1] form the 2-flop synchronizer, [2] is the edge-detect delay stage
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;
    logic       scl_s, scl_dly, sda_dly;

    // Shift the raw pins into the pipelines
    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl};
        sda_pipe_d = {sda_pipe_q[1:0], sda};
    end

    // Pipelines reset to the idle-bus level so reset release creates no edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe_q <= 3'b111;
            sda_pipe_q <= 3'b111;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
        end
    end

    // Edges and bus conditions from the synchronized samples only
    always_comb begin
        scl_s     = scl_pipe_q[1];
        scl_dly   = scl_pipe_q[2];
        sda_s     = sda_pipe_q[1];
        sda_dly   = sda_pipe_q[2];
        scl_rise  = scl_s & ~scl_dly;
        scl_fall  = ~scl_s & scl_dly;
        start_det = scl_s & scl_dly & sda_dly & ~sda_s;
        stop_det  = scl_s & scl_dly & ~sda_dly & sda_s;
    end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// rtl/i2c_slave_ctrl.sv - I2C target FSM and shift register; I2C_GENERAL_CALL_EN adds general-call writes
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h6A
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    inout  wire  sda,
    i2c_slave_ctrl_if.slave bus
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst_n     (reset),
        .scl       (scl),
        .sda       (sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t     state, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_out_q, data_out_d;
    logic       sda_oe_q, sda_oe_d;
    logic       data_ready_q, data_ready_d;
    logic       ack_error_q, ack_error_d;
    logic       start_q, start_d;
    logic       nack_q, nack_d;
    logic       addr_ack;

    // Address byte is shifted MSB first, so R/W lands in bit 0
`ifdef I2C_GENERAL_CALL_EN
    assign addr_ack = (shift_q[7:1] == SLAVE_ADDR) ||
                      ((shift_q[7:1] == GEN_CALL_ADDR) && !shift_q[0]);
`else
    assign addr_ack = (shift_q[7:1] == SLAVE_ADDR);
`endif

    // State register and datapath flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'd0;
            data_out_q   <= 8'd0;
            sda_oe_q     <= 1'b0;
            data_ready_q <= 1'b0;
            ack_error_q  <= 1'b0;
            start_q      <= 1'b0;
            nack_q       <= 1'b0;
        end else begin
            state        <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            sda_oe_q     <= sda_oe_d;
            data_ready_q <= data_ready_d;
            ack_error_q  <= ack_error_d;
            start_q      <= start_d;
            nack_q       <= nack_d;
        end
    end

    // Next-state and datapath updates; START/STOP override every state
    always_comb begin
        state_d      = state;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        sda_oe_d     = sda_oe_q;
        data_ready_d = 1'b0;
        ack_error_d  = ack_error_q;
        start_d      = 1'b0;
        nack_d       = nack_q;
        if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 4'd0;
            sda_oe_d    = 1'b0;
            start_d     = 1'b1;
            ack_error_d = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = addr_ack;
                        state_d   = addr_ack ? ST_ADDR_ACK : ST_IDLE;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            shift_d  = bus.data_in;
                            sda_oe_d = ~bus.data_in[7];
                            state_d  = ST_READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            data_out_d   = {shift_q[6:0], sda_s};
                            data_ready_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b1;
                        state_d   = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                ST_READ: begin
                    // bit 7 went out on entry; each later fall shifts the next bit out
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                        state_d   = ST_READ_ACK;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise && bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                        nack_d    = sda_s;
                        if (sda_s) begin
                            ack_error_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        bit_cnt_d = 4'd0;
                        if (nack_q) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_IDLE;
                        end else begin
                            shift_d  = bus.data_in;
                            sda_oe_d = ~bus.data_in[7];
                            state_d  = ST_READ;
                        end
                    end
                end
                default: begin
                    bit_cnt_d = 4'd0;
                    sda_oe_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    // Byte-side outputs straight from their flops
    always_comb begin
        bus.data_out   = data_out_q;
        bus.data_ready = data_ready_q;
        bus.ack_error  = ack_error_q;
        bus.start      = start_q;
    end

    // Open-drain pad: only ever pulls low
    assign sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb/tb_i2c_slave_ctrl.sv - self-checking bench for i2c_slave_ctrl
module tb_i2c_slave_ctrl;
    import i2c_pkg::*;

    localparam int Q = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic scl_m   = 1'b1;
    logic m_low   = 1'b0;
    wire  sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_ctrl_if bus_if ();

    i2c_slave_ctrl #(.SLAVE_ADDR(7'h6A)) dut (
        .clk   (clk),
        .reset (reset_n),
        .scl   (scl_m),
        .sda   (sda),
        .bus   (bus_if)
    );

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data;
        logic       m_nack;
        logic       exp_ack;
        logic       exp_ack_err;
    } vec_t;

    vec_t       vecs [9];
    int         checks = 0;
    int         errors = 0;
    int         start_cnt = 0;
    logic [7:0] exp_q [$];
    logic [2:0] trace [$];
    logic [2:0] prev_state = 3'd0;
    logic [7:0] last_wr = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_state = 3'd0;
        end else begin
            if (bus_if.start) start_cnt++;
            if (bus_if.data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data_ready: got data_out 0x%0h, want no pulse", bus_if.data_out);
                end else begin
                    chk("data_out", {24'd0, bus_if.data_out}, {24'd0, exp_q.pop_front()});
                end
            end
            if (dut.state != prev_state) trace.push_back(dut.state);
            prev_state = dut.state;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clk_bit(input logic b, output logic s);
        m_low = ~b;
        #Q; scl_m = 1'b1;
        #Q; s = sda;
        #Q; scl_m = 1'b0;
        #Q;
    endtask

    task automatic start_cond();
        m_low = 1'b0; scl_m = 1'b1;
        #Q; m_low = 1'b1;
        #Q; scl_m = 1'b0;
        #Q;
    endtask

    task automatic stop_cond();
        m_low = 1'b1;
        #Q; scl_m = 1'b1;
        #Q; m_low = 1'b0;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
        clk_bit(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic nack);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, d);
            b[i] = d;
        end
        clk_bit(nack, d);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic       ack;
        logic [7:0] rb;
        logic [2:0] exp_tr [6];
        exp_tr = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd4, 3'd0};
        bus_if.data_in = v.data;
        start_cnt = 0;
        trace.delete();
        start_cond();
        chk($sformatf("v%0d_start_pulse", idx), start_cnt, 1);
        chk($sformatf("v%0d_ack_error_clr", idx), {31'd0, bus_if.ack_error}, 0);
        send_byte(v.addr_byte, ack);
        chk($sformatf("v%0d_addr_ack_sda", idx), {31'd0, ack}, {31'd0, !v.exp_ack});
        if (v.exp_ack && !ack) begin
            if (!v.addr_byte[0]) begin
                exp_q.push_back(v.data);
                last_wr = v.data;
                send_byte(v.data, ack);
                chk($sformatf("v%0d_data_ack_sda", idx), {31'd0, ack}, 0);
            end else begin
                recv_byte(rb, v.m_nack);
                chk($sformatf("v%0d_read_byte", idx), {24'd0, rb}, {24'd0, v.data});
            end
        end else begin
            chk($sformatf("v%0d_nack_idle", idx), {29'd0, dut.state}, {29'd0, ST_IDLE});
        end
        stop_cond();
        #50;
        chk($sformatf("v%0d_state_idle", idx), {29'd0, dut.state}, {29'd0, ST_IDLE});
        chk($sformatf("v%0d_sda_released", idx), {31'd0, sda}, 1);
        chk($sformatf("v%0d_ack_error", idx), {31'd0, bus_if.ack_error}, {31'd0, v.exp_ack_err});
        chk($sformatf("v%0d_data_out_hold", idx), {24'd0, bus_if.data_out}, {24'd0, last_wr});
        chk($sformatf("v%0d_pending_writes", idx), exp_q.size(), 0);
        if (v.exp_ack && v.addr_byte[0] && !v.m_nack) begin
            chk($sformatf("v%0d_trace_len", idx), trace.size(), 6);
            for (int i = 0; i < 6 && i < trace.size(); i++)
                chk($sformatf("v%0d_trace_%0d", idx, i), {29'd0, trace[i]}, {29'd0, exp_tr[i]});
        end
    endtask

    initial begin
        logic ack;
        logic d;
        logic gc_ack;
`ifdef I2C_GENERAL_CALL_EN
        gc_ack = 1'b1;
`else
        gc_ack = 1'b0;
`endif
        vecs[0] = '{8'hD4, 8'hAA, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hD5, 8'hCC, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hA0, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'hD5, 8'h35, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{8'hD4, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'hD5, 8'h81, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{8'hD4, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h5A, 1'b0, gc_ack, 1'b0};
        vecs[8] = '{8'h01, 8'h77, 1'b1, 1'b0, 1'b0};

        bus_if.data_in = 8'h00;
        #100;
        chk("rst_state", {29'd0, dut.state}, {29'd0, ST_IDLE});
        chk("rst_sda", {31'd0, sda}, 1);
        chk("rst_data_out", {24'd0, bus_if.data_out}, 0);
        chk("rst_data_ready", {31'd0, bus_if.data_ready}, 0);
        chk("rst_ack_error", {31'd0, bus_if.ack_error}, 0);
        chk("rst_start", {31'd0, bus_if.start}, 0);
        reset_n = 1'b1;
        #100;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // STOP in the middle of a data byte
        start_cond();
        send_byte(8'hD4, ack);
        chk("abort_addr_ack", {31'd0, ack}, 0);
        clk_bit(1'b0, d);
        clk_bit(1'b1, d);
        clk_bit(1'b0, d);
        clk_bit(1'b1, d);
        stop_cond();
        chk("abort_stop_state", {29'd0, dut.state}, {29'd0, ST_IDLE});
        chk("abort_stop_sda", {31'd0, sda}, 1);
        chk("abort_stop_data_out", {24'd0, bus_if.data_out}, {24'd0, last_wr});

        // Reset while the address ACK is being driven
        start_cond();
        for (int i = 7; i >= 0; i--) clk_bit(1'(8'hD4 >> i), d);
        m_low = 1'b0;
        #Q; scl_m = 1'b1;
        #Q;
        chk("reset_pre_ack_low", {31'd0, sda}, 0);
        reset_n = 1'b0;
        #1;
        chk("reset_state", {29'd0, dut.state}, {29'd0, ST_IDLE});
        chk("reset_sda", {31'd0, sda}, 1);
        chk("reset_data_out", {24'd0, bus_if.data_out}, 0);
        last_wr = 8'h00;
        #Q;
        reset_n = 1'b1;
        #Q;
        run_vec('{8'hD4, 8'h3C, 1'b0, 1'b1, 1'b0}, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
